// File: rtl/mpdmac_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpdmac_sched_pkg
// Description : Shared types and constants for the mirror-padding DMA
//               command scheduler: FSM state encoding, the legal matrix
//               width window and the per-channel descriptor layout.
// Revision    : 1.0 - initial release
// ============================================================================
package mpdmac_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_BUSY     = 3'd3,
    ST_COMPLETE = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  // Mirroring reads column/row N-2, so N must be at least 3.
  localparam int unsigned MIN_WIDTH = 3;
  // The engine's 4-bit burst length carries N+1, so N may not exceed 14.
  localparam int unsigned MAX_WIDTH = 14;

  // One latched matrix-padding descriptor
  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [5:0]  width;
  } desc_t;

  // True when the engine can legally process a matrix of width w.
  function automatic logic width_ok(input logic [5:0] w);
    return (w >= 6'(MIN_WIDTH)) && (w <= 6'(MAX_WIDTH));
  endfunction

endpackage : mpdmac_sched_pkg
`default_nettype wire

// File: rtl/mpdmac_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : mpdmac_rr_arb
// Description : Combinational round-robin arbiter. Grants the first set
//               request bit at or after the pointer, searching cyclically.
// Revision    : 1.0 - initial release
// Ports       : req_i     - request vector (one bit per channel)
//               ptr_i     - round-robin start position
//               gnt_o     - one-hot grant (all-zero when no request)
//               idx_o     - encoded index of the granted channel
//               any_req_o - at least one request bit is set
// ============================================================================
module mpdmac_rr_arb #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [2:0]        ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [2:0]        idx_o,
  output logic              any_req_o
);

  // Rotate the request vector so the pointer position lands on bit 0;
  // a plain priority search over the rotated vector is then round-robin.
  logic [NUM_CH-1:0] req_rot;
  assign req_rot = NUM_CH'({req_i, req_i} >> ptr_i);

  logic       found;
  logic [3:0] sum;

  always_comb begin
    idx_o = 3'd0;
    found = 1'b0;
    sum   = 4'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        // Undo the rotation: index = (ptr + i) mod NUM_CH
        sum = {1'b0, ptr_i} + 4'(i);
        if (sum >= 4'(NUM_CH)) begin
          sum = sum - 4'(NUM_CH);
        end
        idx_o = sum[2:0];
      end
    end
  end

  assign any_req_o = |req_i;

  for (genvar j = 0; j < NUM_CH; j++) begin : g_gnt
    assign gnt_o[j] = any_req_o && (idx_o == 3'(j));
  end

endmodule : mpdmac_rr_arb
`default_nettype wire

// File: rtl/mpdmac_sched.sv
`default_nettype none
// ============================================================================
// Module      : mpdmac_sched
// Description : Multi-channel command scheduler for the mirror-padding DMA
//               engine. Holds one descriptor per channel, validates the
//               matrix width, arbitrates round-robin, sequences the engine
//               start/done handshake and reports completion via status bits
//               and a level interrupt.
// Revision    : 1.0 - initial release
// Config      : MPDMAC_SCHED_TIMEOUT_EN - enables the WAIT_ACK/BUSY watchdog
//               (limit TIMEOUT_CYCLES); otherwise fault_o is tied low.
// Ports       : clk, rst_n (sync, active-low)
//               req_valid_i/req_ready_o      - per-channel descriptor handshake
//               req_src_i/req_dst_i/req_width_i - flattened descriptor fields
//               cmpl_valid_o/cmpl_err_o      - completion pulse and error flag
//               irq_status_o/irq_clr_i/irq_o - sticky status, W1C, level IRQ
//               eng_*                        - shared engine command interface
//               busy_o/cur_ch_o/fault_o      - scheduler status
// ============================================================================
module mpdmac_sched
  import mpdmac_sched_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    req_valid_i,
  output logic [NUM_CH-1:0]    req_ready_o,
  input  logic [NUM_CH*32-1:0] req_src_i,
  input  logic [NUM_CH*32-1:0] req_dst_i,
  input  logic [NUM_CH*6-1:0]  req_width_i,
  output logic [NUM_CH-1:0]    cmpl_valid_o,
  output logic                 cmpl_err_o,
  output logic [NUM_CH-1:0]    irq_status_o,
  input  logic [NUM_CH-1:0]    irq_clr_i,
  output logic                 irq_o,
  output logic [31:0]          eng_src_addr_o,
  output logic [31:0]          eng_dst_addr_o,
  output logic [5:0]           eng_mat_width_o,
  output logic                 eng_start_o,
  input  logic                 eng_done_i,
  output logic                 busy_o,
  output logic [2:0]           cur_ch_o,
  output logic                 fault_o
);

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES > 65535) begin : g_param_err
    $error("mpdmac_sched: NUM_CH must be 2..8 and TIMEOUT_CYCLES must fit 16 bits");
  end

  state_e            state_q;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] irq_q, irq_d;
  logic [NUM_CH-1:0] cur_oh_q;
  logic [NUM_CH-1:0] cmpl_valid_q;
  logic              cmpl_err_q;
  logic [2:0]        rr_ptr_q;
  logic [2:0]        cur_ch_q;
  logic [31:0]       eng_src_q, eng_dst_q;
  logic [5:0]        eng_width_q;
  logic              eng_start_q;
  desc_t             desc_q [NUM_CH];

  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] gnt;
  logic [2:0]        gnt_idx;
  logic              any_req;
  desc_t             sel_desc;
  logic [2:0]        next_ptr;

  assign accept = req_valid_i & ~pend_q;

  mpdmac_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i     (pend_q),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .idx_o     (gnt_idx),
    .any_req_o (any_req)
  );

  // Descriptor mux driven by the one-hot grant
  always_comb begin
    sel_desc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) begin
        sel_desc = desc_q[c];
      end
    end
  end

  assign next_ptr = (cur_ch_q == 3'(NUM_CH - 1)) ? 3'd0 : cur_ch_q + 3'd1;

  // An accept and the COMPLETE clear can never hit the same channel because
  // a channel only accepts while its pend bit is low.
  always_comb begin
    pend_d = pend_q | accept;
    if (state_q == ST_COMPLETE) begin
      pend_d = pend_d & ~cur_oh_q;
    end
  end

  // Clear first, then set, so a coinciding set wins.
  always_comb begin
    irq_d = irq_q & ~irq_clr_i;
    if (state_q == ST_COMPLETE) begin
      irq_d = irq_d | cur_oh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      irq_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        desc_q[c] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      irq_q  <= irq_d;
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept[c]) begin
          desc_q[c] <= '{src:   req_src_i[c*32 +: 32],
                         dst:   req_dst_i[c*32 +: 32],
                         width: req_width_i[c*6 +: 6]};
        end
      end
    end
  end

`ifdef MPDMAC_SCHED_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_cnt_q;
  logic        tmo_hit_q;
  logic        fault_q;
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

  // Main FSM; all engine and completion outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= 3'd0;
      cur_ch_q     <= 3'd0;
      cur_oh_q     <= '0;
      eng_src_q    <= 32'd0;
      eng_dst_q    <= 32'd0;
      eng_width_q  <= 6'd0;
      eng_start_q  <= 1'b0;
      cmpl_valid_q <= '0;
      cmpl_err_q   <= 1'b0;
`ifdef MPDMAC_SCHED_TIMEOUT_EN
      tmo_cnt_q    <= 16'd0;
      tmo_hit_q    <= 1'b0;
      fault_q      <= 1'b0;
`endif
    end else begin
      eng_start_q  <= 1'b0;
      cmpl_valid_q <= '0;
      cmpl_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            eng_src_q   <= sel_desc.src;
            eng_dst_q   <= sel_desc.dst;
            eng_width_q <= sel_desc.width;
            cur_ch_q    <= gnt_idx;
            cur_oh_q    <= gnt;
            if (width_ok(sel_desc.width)) begin
              eng_start_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end else begin
              // Illegal width: report an error without touching the engine
              cmpl_valid_q <= gnt;
              cmpl_err_q   <= 1'b1;
              state_q      <= ST_COMPLETE;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // done still reads high until the engine has taken the start
          if (!eng_done_i) begin
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (eng_done_i) begin
            cmpl_valid_q <= cur_oh_q;
            state_q      <= ST_COMPLETE;
          end
        end
        ST_COMPLETE: begin
          rr_ptr_q <= next_ptr;
`ifdef MPDMAC_SCHED_TIMEOUT_EN
          if (tmo_hit_q) begin
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end else begin
            state_q <= ST_IDLE;
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

`ifdef MPDMAC_SCHED_TIMEOUT_EN
      // Watchdog overrides the normal WAIT_ACK/BUSY progression
      if (state_q == ST_ISSUE) begin
        tmo_cnt_q <= 16'd0;
      end else if (state_q == ST_WAIT_ACK || state_q == ST_BUSY) begin
        if (tmo_cnt_q == TMO_LIMIT) begin
          cmpl_valid_q <= cur_oh_q;
          cmpl_err_q   <= 1'b1;
          tmo_hit_q    <= 1'b1;
          state_q      <= ST_COMPLETE;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
      end
`endif
    end
  end

  assign req_ready_o     = ~pend_q;
  assign cmpl_valid_o    = cmpl_valid_q;
  assign cmpl_err_o      = cmpl_err_q;
  assign irq_status_o    = irq_q;
  assign irq_o           = |irq_q;
  assign eng_src_addr_o  = eng_src_q;
  assign eng_dst_addr_o  = eng_dst_q;
  assign eng_mat_width_o = eng_width_q;
  assign eng_start_o     = eng_start_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign cur_ch_o        = cur_ch_q;

endmodule : mpdmac_sched
`default_nettype wire

// File: tb/tb_mpdmac_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpdmac_sched
// Description : Directed self-checking bench for mpdmac_sched (NUM_CH=4)
//               with a small behavioural engine model (3-cycle runtime).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpdmac_sched;

  localparam int NCH     = 4;
  localparam int ENG_LAT = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   req_valid_i;
  logic [NCH-1:0]   req_ready_o;
  logic [NCH*32-1:0] req_src_i;
  logic [NCH*32-1:0] req_dst_i;
  logic [NCH*6-1:0] req_width_i;
  logic [NCH-1:0]   cmpl_valid_o;
  logic             cmpl_err_o;
  logic [NCH-1:0]   irq_status_o;
  logic [NCH-1:0]   irq_clr_i;
  logic             irq_o;
  logic [31:0]      eng_src_addr_o;
  logic [31:0]      eng_dst_addr_o;
  logic [5:0]       eng_mat_width_o;
  logic             eng_start_o;
  logic             eng_done_i;
  logic             busy_o;
  logic [2:0]       cur_ch_o;
  logic             fault_o;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int eng_cnt;
  logic eng_hang = 1'b0;

  mpdmac_sched #(
    .NUM_CH         (NCH),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_src_i       (req_src_i),
    .req_dst_i       (req_dst_i),
    .req_width_i     (req_width_i),
    .cmpl_valid_o    (cmpl_valid_o),
    .cmpl_err_o      (cmpl_err_o),
    .irq_status_o    (irq_status_o),
    .irq_clr_i       (irq_clr_i),
    .irq_o           (irq_o),
    .eng_src_addr_o  (eng_src_addr_o),
    .eng_dst_addr_o  (eng_dst_addr_o),
    .eng_mat_width_o (eng_mat_width_o),
    .eng_start_o     (eng_start_o),
    .eng_done_i      (eng_done_i),
    .busy_o          (busy_o),
    .cur_ch_o        (cur_ch_o),
    .fault_o         (fault_o)
  );

  always #5 clk = ~clk;

  // Engine model: done drops after a start and returns high ENG_LAT cycles later
  always @(posedge clk) begin
    if (!rst_n) begin
      eng_done_i <= 1'b1;
      eng_cnt    <= 0;
    end else if (eng_start_o) begin
      eng_done_i <= 1'b0;
      eng_cnt    <= ENG_LAT;
    end else if (!eng_done_i && !eng_hang) begin
      if (eng_cnt <= 1) eng_done_i <= 1'b1;
      else              eng_cnt    <= eng_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (eng_start_o) start_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_ch(input int ch, input logic [31:0] s, input logic [31:0] d,
                         input logic [5:0] w);
    req_valid_i[ch]           = 1'b1;
    req_src_i[ch*32 +: 32]    = s;
    req_dst_i[ch*32 +: 32]    = d;
    req_width_i[ch*6 +: 6]    = w;
  endtask

  // Steps until a completion pulse or the budget runs out; reports whether
  // eng_mat_width_o held its value throughout.
  task automatic wait_cmpl(input int max_cyc, output logic [NCH-1:0] mask,
                           output logic err, output int cyc, output logic stable);
    logic [5:0] ref_w;
    ref_w  = eng_mat_width_o;
    mask   = '0;
    err    = 1'b0;
    cyc    = 0;
    stable = 1'b1;
    while (cyc < max_cyc) begin
      step();
      cyc++;
      if (eng_mat_width_o !== ref_w) stable = 1'b0;
      if (cmpl_valid_o != '0) begin
        mask = cmpl_valid_o;
        err  = cmpl_err_o;
        return;
      end
    end
  endtask

  logic [NCH-1:0] m;
  logic           e;
  logic           st;
  int             cy;
  int             snap;

  initial begin
    rst_n       = 1'b0;
    req_valid_i = '0;
    req_src_i   = '0;
    req_dst_i   = '0;
    req_width_i = '0;
    irq_clr_i   = '0;
    repeat (3) step();

    // ---- reset state ----
    check("rst_ready", req_ready_o, 4'hF);
    check("rst_busy",  busy_o, 1'b0);
    check("rst_start", eng_start_o, 1'b0);
    check("rst_cmpl",  cmpl_valid_o, 4'h0);
    check("rst_irq",   irq_o, 1'b0);
    check("rst_cur",   cur_ch_o, 3'd0);
    check("rst_fault", fault_o, 1'b0);
    rst_n = 1'b1;
    step();

    // ---- single job on ch0 ----
    load_ch(0, 32'h1000, 32'h2000, 6'd4);
    step();                                   // accept edge
    req_valid_i = '0;
    check("sj_ready",  req_ready_o, 4'hE);
    check("sj_nostart", eng_start_o, 1'b0);
    step();                                   // IDLE grants -> ISSUE
    check("sj_start",  eng_start_o, 1'b1);
    check("sj_src",    eng_src_addr_o, 32'h1000);
    check("sj_dst",    eng_dst_addr_o, 32'h2000);
    check("sj_width",  eng_mat_width_o, 6'd4);
    check("sj_busy",   busy_o, 1'b1);
    step();
    check("sj_start_pulse", eng_start_o, 1'b0);
    wait_cmpl(50, m, e, cy, st);
    check("sj_cmpl",   m, 4'h1);
    check("sj_err",    e, 1'b0);
    check("sj_lat",    cy, 4);
    step();
    check("sj_irq",    irq_o, 1'b1);
    check("sj_irqst",  irq_status_o, 4'h1);
    check("sj_ready2", req_ready_o, 4'hF);
    check("sj_idle",   busy_o, 1'b0);
    check("sj_nstart", start_cnt, 1);
    irq_clr_i = 4'h1;
    step();
    irq_clr_i = '0;
    check("sj_irqclr", irq_o, 1'b0);

    // ---- fairness: all four channels at once, pointer reset to 0 ----
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) load_ch(c, 32'h1000_0000 + 32'(c * 256), 32'h2000_0000, 6'd4);
    step();
    req_valid_i = '0;
    check("fair_ready", req_ready_o, 4'h0);
    wait_cmpl(50, m, e, cy, st);
    check("fair_0", m, 4'h1);
    check("fair_0_src", eng_src_addr_o, 32'h1000_0000);
    step();
    check("fair_rdy0", req_ready_o, 4'h1);
    step();                                   // ch1 granted here
    load_ch(0, 32'h3000_0000, 32'h4000_0000, 6'd4);
    step();
    req_valid_i = '0;
    check("fair_reload", req_ready_o, 4'h0);
    wait_cmpl(50, m, e, cy, st);
    check("fair_1", m, 4'h2);
    check("fair_1_cur", cur_ch_o, 3'd1);
    wait_cmpl(50, m, e, cy, st);
    check("fair_2", m, 4'h4);
    check("fair_2_src", eng_src_addr_o, 32'h1000_0200);
    wait_cmpl(50, m, e, cy, st);
    check("fair_3", m, 4'h8);
    wait_cmpl(50, m, e, cy, st);
    check("fair_0b", m, 4'h1);
    check("fair_0b_src", eng_src_addr_o, 32'h3000_0000);
    step();
    irq_clr_i = 4'hF;
    step();
    irq_clr_i = '0;
    check("fair_irqclr", irq_o, 1'b0);

    // ---- width reject: N=2 on ch2, N=15 on ch3 ----
    snap = start_cnt;
    load_ch(2, 32'h5000, 32'h6000, 6'd2);
    step();
    req_valid_i = '0;
    check("rej2_early", cmpl_valid_o, 4'h0);
    step();
    check("rej2_cmpl", cmpl_valid_o, 4'h4);
    check("rej2_err",  cmpl_err_o, 1'b1);
    check("rej2_cur",  cur_ch_o, 3'd2);
    check("rej2_nostart", eng_start_o, 1'b0);
    irq_clr_i = 4'h4;                         // clear coincides with set
    step();
    irq_clr_i = '0;
    check("rej2_setwins", irq_status_o, 4'h4);
    check("rej2_ready", req_ready_o, 4'hF);
    irq_clr_i = 4'h4;
    step();
    irq_clr_i = '0;
    check("rej2_clr", irq_status_o, 4'h0);
    load_ch(3, 32'h7000, 32'h8000, 6'd15);
    step();
    req_valid_i = '0;
    step();
    check("rej15_cmpl", cmpl_valid_o, 4'h8);
    check("rej15_err",  cmpl_err_o, 1'b1);
    step();
    check("rej_nstart", start_cnt, snap);
    load_ch(1, 32'h9000, 32'hA000, 6'd5);
    step();
    req_valid_i = '0;
    wait_cmpl(50, m, e, cy, st);
    check("rej_next", m, 4'h2);
    check("rej_next_err", e, 1'b0);
    check("rej_next_start", start_cnt, snap + 1);
    step();

    // ---- boundary widths 3 and 14 ----
    load_ch(0, 32'hB000, 32'hC000, 6'd3);
    step();
    req_valid_i = '0;
    step();
    check("b3_start", eng_start_o, 1'b1);
    check("b3_width", eng_mat_width_o, 6'd3);
    wait_cmpl(50, m, e, cy, st);
    check("b3_cmpl", m, 4'h1);
    check("b3_err", e, 1'b0);
    check("b3_stable", st, 1'b1);
    step();
    load_ch(1, 32'hD000, 32'hE000, 6'd14);
    step();
    req_valid_i = '0;
    step();
    check("b14_start", eng_start_o, 1'b1);
    check("b14_width", eng_mat_width_o, 6'd14);
    wait_cmpl(50, m, e, cy, st);
    check("b14_cmpl", m, 4'h2);
    check("b14_err", e, 1'b0);
    check("b14_stable", st, 1'b1);
    check("b14_width_end", eng_mat_width_o, 6'd14);
    step();

    // ---- reset while the engine is busy ----
    load_ch(2, 32'h1111, 32'h2222, 6'd6);
    load_ch(3, 32'h3333, 32'h4444, 6'd6);
    step();
    req_valid_i = '0;
    repeat (3) step();                        // ISSUE, WAIT_ACK, BUSY
    check("mid_busy", busy_o, 1'b1);
    rst_n = 1'b0;
    step();
    check("mid_rst_busy",  busy_o, 1'b0);
    check("mid_rst_ready", req_ready_o, 4'hF);
    check("mid_rst_irq",   irq_o, 1'b0);
    check("mid_rst_src",   eng_src_addr_o, 32'h0);
    check("mid_rst_cur",   cur_ch_o, 3'd0);
    rst_n = 1'b1;
    snap = start_cnt;
    wait_cmpl(8, m, e, cy, st);
    check("mid_no_cmpl", m, 4'h0);
    check("mid_no_start", start_cnt, snap);
    check("mid_idle", busy_o, 1'b0);

`ifdef MPDMAC_SCHED_TIMEOUT_EN
    // ---- watchdog: engine never finishes ----
    eng_hang = 1'b1;
    snap = start_cnt;
    load_ch(0, 32'h5555, 32'h6666, 6'd4);
    step();
    req_valid_i = '0;
    wait_cmpl(200, m, e, cy, st);
    check("tmo_cmpl", m, 4'h1);
    check("tmo_err", e, 1'b1);
    step();
    check("tmo_fault", fault_o, 1'b1);
    load_ch(1, 32'h7777, 32'h8888, 6'd4);
    step();
    req_valid_i = '0;
    repeat (20) step();
    check("tmo_nostart", start_cnt, snap + 1);
    check("tmo_pend", req_ready_o, 4'hD);
    check("tmo_hold", fault_o, 1'b1);
`else
    check("no_fault", fault_o, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mpdmac_sched
`default_nettype wire

// File: doc/mpdmac_sched.md
# mpdmac_sched

Multi-channel command scheduler in front of the mirror-padding DMA engine. It accepts one matrix-padding descriptor per requester channel, validates the matrix width, and picks one pending channel by round-robin arbitration. It sequences the engine's `start`/`done` handshake and reports per-channel completion and error through status bits and a level interrupt. It sits between the CFG/SFR layer (or several CPU-side requesters) and the single shared engine instance.

## Interface
Parameters:
- NUM_CH, 4: number of requester channels (2..8).
- TIMEOUT_CYCLES, 65535: watchdog limit. Used only when the timeout macro is defined.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  NUM_CH  descriptor valid, one bit per channel.
- req_ready_o  out  NUM_CH  channel holding register empty.
- req_src_i  in  NUM_CH×32  source base address per channel.
- req_dst_i  in  NUM_CH×32  destination base address per channel.
- req_width_i  in  NUM_CH×6  matrix width N per channel.
- cmpl_valid_o  out  NUM_CH  one-cycle completion pulse.
- cmpl_err_o  out  1  error flag, qualified by any cmpl_valid_o bit.
- irq_status_o  out  NUM_CH  sticky completion bits.
- irq_clr_i  in  NUM_CH  write-1-to-clear for irq_status_o.
- irq_o  out  1  OR of irq_status_o.
- eng_src_addr_o / eng_dst_addr_o  out  32  engine source/destination address.
- eng_mat_width_o  out  6  engine width.
- eng_start_o  out  1  engine start.
- eng_done_i  in  1  engine done (1 when idle or finished).
- busy_o  out  1  state is not IDLE.
- cur_ch_o  out  3  channel currently granted.
- fault_o  out  1  watchdog fault, sticky.

## Operation
- Reset values:
  - All outputs are 0, except req_ready_o, which is all-ones.
  - pend[] is cleared.
  - The round-robin pointer is 0.
  - State is IDLE.
- Descriptor accept:
  - A descriptor is accepted on channel c when req_valid_i[c] and req_ready_o[c] are both 1.
  - On accept, the fields are latched and pend[c] is set.
  - req_ready_o[c] = !pend[c].
- States: IDLE, ISSUE, WAIT_ACK, BUSY, COMPLETE, FAULT.
- IDLE:
  - If any pend bit is set, grant the first pending channel at or after the RR pointer, searching cyclically.
  - Register the granted fields onto the eng_* outputs and set cur_ch_o.
  - If the width is in MIN_WIDTH..MAX_WIDTH (3..14), go to ISSUE.
  - Otherwise, go to COMPLETE with err=1. The engine is never started in this case.
- ISSUE: eng_start_o=1 for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK: eng_start_o=0. Wait for eng_done_i==0, then go to BUSY.
- BUSY: wait for eng_done_i==1, then go to COMPLETE.
- COMPLETE (one cycle):
  - Pulse cmpl_valid_o[cur].
  - Drive cmpl_err_o.
  - Set irq_status_o[cur] and clear pend[cur].
  - Set RR pointer = cur+1 mod NUM_CH.
  - Go to IDLE.
- The eng_* address and width outputs stay stable from ISSUE through COMPLETE.
- Width rule:
  - 14 is the maximum because the engine's 4-bit burst length carries N+1.
  - 3 is the minimum because mirroring reads column/row N-2.
  - Addresses pass through unmodified. No alignment check is performed.

## Timing
- Latency:
  - Accept at cycle t → pend visible at t+1.
  - If the scheduler is in IDLE at t+1, eng_start_o is asserted at t+2.
- Best-case scheduler overhead per job is 4 cycles beyond the engine runtime.
- A rejected-width job completes 2 cycles after pend is set.
- Same channel in COMPLETE: req_ready_o[c] rises the cycle after COMPLETE. A new accept and a clear never coincide.
- irq_clr_i[c] in the same cycle as a set of irq_status_o[c]: the set wins.
- Accepts on other channels are allowed in every state, including while the engine is busy.
- Reset mid-operation: everything returns to reset values in the next cycle and pending descriptors are discarded. The engine shares rst_n.

## Configuration
- MPDMAC_SCHED_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT_ACK and increments in WAIT_ACK and BUSY.
  - When the counter reaches TIMEOUT_CYCLES: COMPLETE with err=1, then FAULT.
  - FAULT sets fault_o=1, stops further issues (req_ready_o still follows pend) and holds until reset.
- Undefined: no counter. The scheduler waits indefinitely, fault_o is tied 0 and FAULT is unreachable.

## Structure
- Package mpdmac_sched_pkg:
  - State enum.
  - MIN_WIDTH=3, MAX_WIDTH=14.
  - Descriptor struct {src, dst, width}.
- Sub-module mpdmac_rr_arb: combinational round-robin grant from a pend vector and a pointer. It outputs a one-hot grant, an encoded index and any_req.

## Test plan
- Single job: ch0 src=0x1000, dst=0x2000, N=4 → eng_start_o is a single pulse 2 cycles after accept; cmpl_valid_o[0] fires with err=0; irq_o=1; irq_clr_i[0] drops irq_o the next cycle.
- Fairness: all 4 channels load in the same cycle, pointer at 0 → service order 0,1,2,3. Reload ch0 during ch1's job → order continues 2,3,0.
- Width reject: N=2 and N=15 → eng_start_o never asserts; cmpl_err_o=1 two cycles after pend; the next valid job runs normally.
- Boundary widths: N=3 and N=14 → both issued; eng_mat_width_o is held stable until done.
- Timeout (macro on, TIMEOUT_CYCLES=100): model holds eng_done_i=0 → err completion at 100 cycles; fault_o=1; no further eng_start_o until rst_n.
- Reset mid-BUSY: assert rst_n=0 → next cycle busy_o=0, pend cleared, req_ready_o all-ones.
